band_mixer: RTL

//  Downstream stage of the 8-band FIR bank. Captures per-band outputs at each sample boundary,

---
 rtl/band_mixer_if.sv | 24 ++
 rtl/band_mixer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/band_mixer_if.sv
// Band-bank input bus and mixed-sample valid/ready output stream of band_mixer.
// master = mixer side (consumes bank samples, produces the stream); slave = its peers.
interface band_mixer_if #(
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int FILTER_OUT_BITS   = 16,
  parameter int MIX_OUT_BITS      = 16
);
  logic                                         phase_min;
  logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] filtered_outs;
  logic [NUMBER_OF_FILTERS-1:0]                 band_mask;
  logic [MIX_OUT_BITS-1:0]                      mix_data;
  logic                                         mix_valid;
  logic                                         mix_ready;

  modport master (
    input  phase_min, filtered_outs, band_mask, mix_ready,
    output mix_data, mix_valid
  );

  modport slave (
    output phase_min, filtered_outs, band_mask, mix_ready,
    input  mix_data, mix_valid
  );
endinterface

// File: rtl/band_mixer.sv
// Sequential masked band summer with saturation, feeding a small FIFO; capture-to-write 10 enabled cycles.
// Backpressure: mix_ready pops the FIFO; a full FIFO drops the new sample. BAND_MIXER_CLIP_CNT_EN adds clip_count.
module band_mixer #(
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int FILTER_OUT_BITS   = 16,
  parameter int MIX_OUT_BITS      = 16,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_enable,
  band_mixer_if.master       bus,
  output logic               overrun,
  output logic [7:0]         drop_count
`ifdef BAND_MIXER_CLIP_CNT_EN
  ,
  output logic [15:0]        clip_count
`endif
);
  localparam int ACC_BITS = FILTER_OUT_BITS + $clog2(NUMBER_OF_FILTERS) + 1;
  localparam int IDX_W    = $clog2(NUMBER_OF_FILTERS);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((64'sd1 <<< (MIX_OUT_BITS-1)) - 64'sd1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT, PUSH} state_t;
  state_t state, state_n;

  logic signed [FILTER_OUT_BITS-1:0] band_q [NUMBER_OF_FILTERS];
  logic [NUMBER_OF_FILTERS-1:0]      mask_q;
  logic [IDX_W-1:0]                  idx;
  logic signed [ACC_BITS-1:0]        acc;
  logic signed [ACC_BITS-1:0]        addend;
  logic [MIX_OUT_BITS-1:0]           res;
  logic                              clamp_hi, clamp_lo;

  logic [MIX_OUT_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count;
  logic [MIX_OUT_BITS-1:0] last_q;
  logic                    push_req, push, pop, full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            state <= IDLE;
    else if (clk_enable) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.phase_min) state_n = ACCUM;
      ACCUM:   if (idx == IDX_W'(NUMBER_OF_FILTERS-1)) state_n = SAT;
      SAT:     state_n = PUSH;
      PUSH:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign addend   = mask_q[idx] ? {{(ACC_BITS-FILTER_OUT_BITS){band_q[idx][FILTER_OUT_BITS-1]}}, band_q[idx]}
                                : '0;
  assign clamp_hi = acc > SAT_MAX;
  assign clamp_lo = acc < SAT_MIN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUMBER_OF_FILTERS; i++) band_q[i] <= '0;
      mask_q <= '0;
      idx    <= '0;
      acc    <= '0;
      res    <= '0;
    end else if (clk_enable) begin
      case (state)
        IDLE: if (bus.phase_min) begin
          // Snapshot the whole bank so later input/mask changes cannot leak into this sum.
          for (int i = 0; i < NUMBER_OF_FILTERS; i++)
            band_q[i] <= bus.filtered_outs[i*FILTER_OUT_BITS +: FILTER_OUT_BITS];
          mask_q <= bus.band_mask;
          acc    <= '0;
          idx    <= '0;
        end
        ACCUM: begin
          acc <= acc + addend;
          idx <= idx + 1'b1;
        end
        SAT: res <= clamp_hi ? SAT_MAX[MIX_OUT_BITS-1:0] :
                    clamp_lo ? SAT_MIN[MIX_OUT_BITS-1:0] : acc[MIX_OUT_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Pop runs regardless of clk_enable so the serializer never stalls on a bank freeze.
  assign pop      = (count != '0) && bus.mix_ready;
  assign full     = count == (PTR_W+1)'(FIFO_DEPTH);
  assign push_req = clk_enable && (state == PUSH);
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign bus.mix_valid = count != '0;
  assign bus.mix_data  = bus.mix_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      if (bus.phase_min && state != IDLE)          overrun    <= 1'b1;
      if (push_req && !push && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

`ifdef BAND_MIXER_CLIP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      clip_count <= '0;
    else if (clk_enable && state == SAT && (clamp_hi || clamp_lo) && clip_count != 16'hFFFF)
      clip_count <= clip_count + 1'b1;
  end
`endif
endmodule
